round_controller: RTL and testbench



---
 rtl/round_controller.sv | 152 +++++++++++++++
 tb/tb_round_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Game-flow FSM for one Dexterity Dash game: arms the countdown timer, picks
// LFSR-driven targets, scores synchronised key presses and stops on timer expiry.
module round_controller #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_btn,
  input  logic [3:0] player_keys,
  input  logic       timer_done,
  output logic       timer_resetn,
  output logic [3:0] target_onehot,
  output logic [6:0] score,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam logic [6:0] SCORE_CEIL = 7'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_NEW_TARGET, S_PLAY, S_RELEASE, S_DONE
  } state_t;

  state_t      r_state, w_next_state;
  logic        r_start_s1, r_start_s2, r_start_s3;
  logic [3:0]  r_key_s1, r_key_s2, r_key_s3;
  logic [15:0] r_lfsr;
  logic [1:0]  r_prev_idx;
  logic        r_has_prev, r_after_hit;
  logic [3:0]  r_target;
  logic [6:0]  r_score;
  logic        r_hit, r_miss, r_game_over, r_timer_resetn;

  logic        w_start_rise, w_key_rise, w_do_hit, w_do_miss, w_lfsr_fb;
  logic [1:0]  w_idx_raw, w_new_idx;
  logic [15:0] w_lfsr_next;

  assign w_start_rise = r_start_s2 & ~r_start_s3;
  assign w_key_rise   = |(r_key_s2 & ~r_key_s3);

  // Fibonacci taps 16,14,13,11; an all-zero register is stuck, so reseed it
  assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_next = (r_lfsr == 16'h0000) ? LFSR_SEED : {w_lfsr_fb, r_lfsr[15:1]};

  // Bump the index when it repeats the last target so consecutive targets differ
  assign w_idx_raw = r_lfsr[1:0];
  assign w_new_idx = (r_has_prev && (w_idx_raw == r_prev_idx)) ? 2'(w_idx_raw + 2'd1) : w_idx_raw;

  // Next-state and press classification
  always_comb begin
    w_next_state = r_state;
    w_do_hit     = 1'b0;
    w_do_miss    = 1'b0;
    case (r_state)
      S_IDLE:       if (w_start_rise) w_next_state = S_ARM; else w_next_state = S_IDLE;
      S_ARM:        w_next_state = S_SETTLE;
      S_SETTLE:     w_next_state = S_NEW_TARGET;
      S_NEW_TARGET: w_next_state = S_PLAY;
      S_PLAY: begin
        if (timer_done) begin
          w_next_state = S_DONE;
        end else if (w_key_rise) begin
          w_next_state = S_RELEASE;
          if (r_key_s2 == r_target) w_do_hit = 1'b1; else w_do_miss = 1'b1;
        end else begin
          w_next_state = S_PLAY;
        end
      end
      S_RELEASE: begin
        if (timer_done) w_next_state = S_DONE;
        else if (r_key_s2 == 4'b0000) w_next_state = r_after_hit ? S_NEW_TARGET : S_PLAY;
        else w_next_state = S_RELEASE;
      end
      S_DONE:       if (w_start_rise) w_next_state = S_ARM; else w_next_state = S_DONE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // State register, input conditioning and LFSR
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_s3 <= 1'b0;
      r_key_s1   <= 4'b0000;
      r_key_s2   <= 4'b0000;
      r_key_s3   <= 4'b0000;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_state    <= w_next_state;
      r_start_s1 <= start_btn;
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      r_key_s1   <= player_keys;
      r_key_s2   <= r_key_s1;
      r_key_s3   <= r_key_s2;
      r_lfsr     <= w_lfsr_next;
    end
  end

  // Registered outputs, score and target bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_target       <= 4'b0000;
      r_prev_idx     <= 2'd0;
      r_has_prev     <= 1'b0;
      r_after_hit    <= 1'b0;
      r_score        <= 7'd0;
      r_hit          <= 1'b0;
      r_miss         <= 1'b0;
      r_game_over    <= 1'b0;
      r_timer_resetn <= 1'b1;
    end else begin
      r_hit          <= w_do_hit;
      r_miss         <= w_do_miss;
      r_game_over    <= (w_next_state == S_DONE);
      r_timer_resetn <= (w_next_state != S_ARM);
      if (r_state == S_NEW_TARGET) begin
        r_target   <= 4'(4'b0001 << w_new_idx);
        r_prev_idx <= w_new_idx;
        r_has_prev <= 1'b1;
      end else if (w_next_state == S_ARM || w_next_state == S_DONE || w_next_state == S_IDLE) begin
        r_target   <= 4'b0000;
        r_has_prev <= (w_next_state == S_ARM) ? 1'b0 : r_has_prev;
      end else begin
        r_target   <= r_target;
      end
      if (w_next_state == S_ARM) begin
        r_score <= 7'd0;
      end else if (w_do_hit) begin
        r_score     <= (r_score >= SCORE_CEIL) ? SCORE_CEIL : r_score + 7'd1;
        r_after_hit <= 1'b1;
      end else if (w_do_miss) begin
        r_score     <= (r_score == 7'd0) ? 7'd0 : r_score - 7'd1;
        r_after_hit <= 1'b0;
      end else begin
        r_score <= r_score;
      end
    end
  end

  assign timer_resetn  = r_timer_resetn;
  assign target_onehot = r_target;
  assign score         = r_score;
  assign hit_pulse     = r_hit;
  assign miss_pulse    = r_miss;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: stimulus pushes expected press results
// into a queue that a negedge monitor drains whenever a hit/miss pulse appears.
module tb_round_controller;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn, start_btn, timer_done;
  logic [3:0] player_keys;
  logic       timer_resetn, hit_pulse, miss_pulse, game_over;
  logic [3:0] target_onehot;
  logic [6:0] score;

  typedef struct packed { logic hit; logic [6:0] score; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_lfsr, m_lfsr_prev;
  int          m_score;
  int          cur_idx;
  bit          have_prev;
  logic [3:0]  exp_target;

  round_controller #(.LFSR_SEED(SEED), .SCORE_MAX(99)) dut (
    .clk(clk), .resetn(resetn), .start_btn(start_btn), .player_keys(player_keys),
    .timer_done(timer_done), .timer_resetn(timer_resetn), .target_onehot(target_onehot),
    .score(score), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic b;
    if (v == 16'h0000) return SEED;
    b = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {b, v[15:1]};
  endfunction

  // Reference LFSR, remembering the value held during the previous cycle
  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    if (!resetn) m_lfsr <= SEED;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (hit_pulse || miss_pulse) begin
      check("pulse_exclusive", int'(hit_pulse && miss_pulse), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {hit_pulse, miss_pulse}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {hit_pulse, miss_pulse}, {e.hit, ~e.hit});
        check("pulse_score", score, e.score);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_target();
    int idx;
    idx = m_lfsr_prev[1:0];
    if (have_prev && idx == cur_idx) idx = (idx + 1) % 4;
    cur_idx    = idx;
    have_prev  = 1'b1;
    exp_target = 4'b0001 << idx;
  endtask

  task automatic do_start();
    start_btn = 1'b1;
    repeat (3) tick();
    check("arm_timer_resetn_low", timer_resetn, 0);
    check("arm_game_over_clear", game_over, 0);
    check("arm_score_clear", score, 0);
    m_score   = 0;
    have_prev = 1'b0;
    tick();
    check("settle_timer_resetn_high", timer_resetn, 1);
    check("settle_target_zero", target_onehot, 0);
    tick();
    timer_done = 1'b0;
    start_btn  = 1'b0;
    tick();
    next_target();
    check("first_target", target_onehot, exp_target);
  endtask

  task automatic press(input logic [3:0] keys, input int hold, input bit exp_hit);
    exp_t e;
    if (exp_hit) m_score = (m_score >= 99) ? 99 : m_score + 1;
    else m_score = (m_score == 0) ? 0 : m_score - 1;
    e.hit   = exp_hit;
    e.score = 7'(m_score);
    exp_q.push_back(e);
    player_keys = keys;
    repeat (3 + hold) tick();
    player_keys = 4'b0000;
    repeat (4) tick();
    if (exp_hit) next_target();
    check(exp_hit ? "target_after_hit" : "target_after_miss", target_onehot, exp_target);
  endtask

  initial begin
    logic [3:0] old_t, rot_t;
    resetn = 1'b0; start_btn = 1'b0; timer_done = 1'b0; player_keys = 4'b0000;
    m_score = 0; cur_idx = 0; have_prev = 1'b0; exp_target = 4'b0000;
    repeat (3) tick();
    check("rst_score", score, 0);
    check("rst_target", target_onehot, 0);
    check("rst_timer_resetn", timer_resetn, 1);
    check("rst_game_over", game_over, 0);
    check("rst_pulses", {hit_pulse, miss_pulse}, 0);
    resetn = 1'b1;
    repeat (4) tick();
    check("idle_target", target_onehot, 0);
    check("idle_timer_resetn", timer_resetn, 1);

    do_start();
    // Wrong single key at score 0 saturates low
    rot_t = {exp_target[2:0], exp_target[3]};
    press(rot_t, 0, 1'b0);
    // Long-held correct key scores once; next target must differ
    old_t = exp_target;
    press(exp_target, 10, 1'b1);
    check("target_differs", int'(target_onehot != old_t), 1);
    repeat (4) press(exp_target, 1, 1'b1);
    check("score_five", score, 5);
    old_t = exp_target;
    rot_t = {exp_target[2:0], exp_target[3]};
    press(rot_t, 2, 1'b0);
    check("score_four", score, 4);
    check("miss_keeps_target", target_onehot, old_t);
    // Correct key plus an extra key is a miss
    rot_t = {exp_target[2:0], exp_target[3]};
    press(exp_target | rot_t, 0, 1'b0);
    check("multi_key_score", score, 3);
    while (m_score < 99) press(exp_target, 0, 1'b1);
    check("score_99", score, 99);
    press(exp_target, 0, 1'b1);
    check("score_sat_99", score, 99);

    // Timer expiry in the same cycle as a correct key rise
    player_keys = exp_target;
    repeat (2) tick();
    timer_done = 1'b1;
    tick();
    check("done_game_over", game_over, 1);
    check("done_target_zero", target_onehot, 0);
    check("done_score_held", score, 99);
    player_keys = 4'b0000;
    repeat (3) tick();
    player_keys = 4'b0001;
    repeat (5) tick();
    player_keys = 4'b0000;
    check("done_ignores_keys", score, 99);
    check("done_still_over", game_over, 1);

    // Restart with timer_done still high through ARM and SETTLE
    repeat (3) tick();
    do_start();
    tick();
    check("play_after_restart", game_over, 0);
    check("play_target_held", target_onehot, exp_target);
    press(exp_target, 0, 1'b1);
    check("restart_score", score, 1);

    // Mid-game reset
    resetn = 1'b0;
    tick();
    check("mid_rst_score", score, 0);
    check("mid_rst_target", target_onehot, 0);
    check("mid_rst_game_over", game_over, 0);
    check("mid_rst_timer_resetn", timer_resetn, 1);
    resetn = 1'b1;
    repeat (3) tick();
    check("post_rst_idle_target", target_onehot, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
